// File: rtl/option_fifo.sv
// Circular word buffer between puzzle loader and nonogram solver (LOAD -> RUN -> IDLE).
// Ports: host load handshake (load_*), solver pop/push (new_line, put_back_to_FIFO/new_option),
// option FWFT head word, status (count/empty/full), sticky overflow/underflow, started pulse, halt.
// Optional: define OPTION_FIFO_HWM_EN to add the high_water output (peak count since LOAD).
module option_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             load_done,
  output logic             started,
  input  logic             new_line,
  output logic [WIDTH-1:0] option,
  input  logic             put_back_to_FIFO,
  input  logic [WIDTH-1:0] new_option,
  input  logic             halt,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
`ifdef OPTION_FIFO_HWM_EN
  ,
  output logic [CW-1:0]    high_water
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;     // last value shown on option, replayed while empty

  logic             run;
  logic             load_acc;
  logic             pop_req;
  logic             push_req;
  logic             do_pop;
  logic             do_push;
  logic             wr_en;
  logic [WIDTH-1:0] wr_word;
  logic             halt_run;
  logic             enter_load;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so DEPTH need not be a power of two.
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign load_ready = (state == LOAD) && !full;
  assign option     = empty ? hold : mem[rd_ptr];

  assign run        = (state == RUN);
  // IDLE always has count==0, so a word offered there is taken while moving to LOAD
  // even though load_ready is still low in that cycle.
  assign load_acc   = load_valid && ((state == IDLE) || ((state == LOAD) && !full));
  assign enter_load = (state == IDLE) && (load_valid || load_done);
  assign pop_req    = run && new_line;
  assign push_req   = run && put_back_to_FIFO;
  assign do_pop     = pop_req && !empty;
  // A same-cycle pop frees the slot, so a push into a full buffer still lands.
  assign do_push    = push_req && (!full || do_pop);
  assign wr_en      = load_acc || do_push;
  assign wr_word    = load_acc ? load_data : new_option;
  assign halt_run   = run && halt;

  always_comb begin
    count_next = count;
    if (wr_en && !do_pop)      count_next = count + CW'(1);
    else if (!wr_en && do_pop) count_next = count - CW'(1);
    count_d = halt_run ? '0 : count_next;
  end

  // Storage has no reset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      started   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      hold      <= '0;
    end else begin
      started <= 1'b0;
      hold    <= option;
      count   <= count_d;

      case (state)
        IDLE: begin
          if (enter_load) begin
            state     <= LOAD;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        LOAD: begin
          if (load_done) begin
            if (count_next == '0) begin
              state <= IDLE;
            end else begin
              state   <= RUN;
              started <= 1'b1;
            end
          end
        end
        RUN: begin
          if (halt) state <= IDLE;
          if (pop_req && empty)               underflow <= 1'b1;
          if (push_req && full && !do_pop)    overflow  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (halt_run) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en)  wr_ptr <= ptr_inc(wr_ptr);
        if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

`ifdef OPTION_FIFO_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water <= '0;
    end else if (enter_load) begin
      high_water <= count_d;
    end else if (count_d > high_water) begin
      high_water <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_option_fifo.sv
module tb_option_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  typedef struct packed {
    logic        lv;
    logic [15:0] ld;
    logic        done;
    logic        pop;
    logic        push;
    logic [15:0] pd;
    logic        halt;
  } in_t;

  typedef struct {
    in_t         i;
    logic [10:0] cnt;
    logic [15:0] opt;
    logic        emp;
    logic        unf;
    logic        st;
    logic        lrdy;
  } vec_t;

  in_t drv;
  int  sel;
  in_t in_a [3];

  always_comb begin
    for (int k = 0; k < 3; k++) in_a[k] = (sel == k) ? drv : '0;
  end

  logic        lr [3], st [3], em [3], fu [3], ov [3], un [3];
  logic [15:0] op [3];
  logic [10:0] cn [3];
  logic [10:0] hw [3];
  logic [2:0]  c4, c5;
  logic [10:0] c1k;
  assign cn[0] = 11'(c4);
  assign cn[1] = 11'(c5);
  assign cn[2] = c1k;

`ifdef OPTION_FIFO_HWM_EN
  logic [2:0]  h4, h5;
  logic [10:0] h1k;
  assign hw[0] = 11'(h4);
  assign hw[1] = 11'(h5);
  assign hw[2] = h1k;
`else
  assign hw[0] = '0;
  assign hw[1] = '0;
  assign hw[2] = '0;
`endif

  option_fifo #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(in_a[0].lv), .load_data(in_a[0].ld), .load_ready(lr[0]), .load_done(in_a[0].done),
    .started(st[0]), .new_line(in_a[0].pop), .option(op[0]),
    .put_back_to_FIFO(in_a[0].push), .new_option(in_a[0].pd), .halt(in_a[0].halt),
    .count(c4), .empty(em[0]), .full(fu[0]), .overflow(ov[0]), .underflow(un[0])
`ifdef OPTION_FIFO_HWM_EN
    , .high_water(h4)
`endif
  );

  option_fifo #(.DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(in_a[1].lv), .load_data(in_a[1].ld), .load_ready(lr[1]), .load_done(in_a[1].done),
    .started(st[1]), .new_line(in_a[1].pop), .option(op[1]),
    .put_back_to_FIFO(in_a[1].push), .new_option(in_a[1].pd), .halt(in_a[1].halt),
    .count(c5), .empty(em[1]), .full(fu[1]), .overflow(ov[1]), .underflow(un[1])
`ifdef OPTION_FIFO_HWM_EN
    , .high_water(h5)
`endif
  );

  option_fifo u_d1k (
    .clk(clk), .rst_n(rst_n),
    .load_valid(in_a[2].lv), .load_data(in_a[2].ld), .load_ready(lr[2]), .load_done(in_a[2].done),
    .started(st[2]), .new_line(in_a[2].pop), .option(op[2]),
    .put_back_to_FIFO(in_a[2].push), .new_option(in_a[2].pd), .halt(in_a[2].halt),
    .count(c1k), .empty(em[2]), .full(fu[2]), .overflow(ov[2]), .underflow(un[2])
`ifdef OPTION_FIFO_HWM_EN
    , .high_water(h1k)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mi(input logic lv, input logic [15:0] ld, input logic done,
                             input logic pop, input logic push, input logic [15:0] pd,
                             input logic halt);
    in_t v;
    v.lv = lv; v.ld = ld; v.done = done; v.pop = pop; v.push = push; v.pd = pd; v.halt = halt;
    return v;
  endfunction

  function automatic vec_t mk(input in_t i, input int cnt, input logic [15:0] opt,
                              input logic emp, input logic unf, input logic stt, input logic lrdy);
    vec_t v;
    v.i = i; v.cnt = 11'(cnt); v.opt = opt; v.emp = emp; v.unf = unf; v.st = stt; v.lrdy = lrdy;
    return v;
  endfunction

  task automatic step(input in_t v);
    drv = v;
    @(posedge clk);
    #1;
  endtask

  in_t  nop;
  vec_t tbl [23];
  logic [15:0] q [$];

  initial begin
    nop   = '0;
    drv   = '0;
    sel   = 2;
    rst_n = 1'b0;

    //            lv  data   done pop push data   halt   cnt opt    emp unf st lrdy
    tbl[0]  = mk(mi(1, 16'h0003, 0, 0, 0, 16'h0000, 0), 1, 16'h0003, 0, 0, 0, 1);
    tbl[1]  = mk(mi(1, 16'h0005, 0, 0, 0, 16'h0000, 0), 2, 16'h0003, 0, 0, 0, 1);
    tbl[2]  = mk(mi(1, 16'h000A, 0, 0, 0, 16'h0000, 0), 3, 16'h0003, 0, 0, 0, 1);
    tbl[3]  = mk(mi(0, 16'h0000, 1, 0, 0, 16'h0000, 0), 3, 16'h0003, 0, 0, 1, 0);
    tbl[4]  = mk(mi(0, 16'h0000, 0, 0, 0, 16'h0000, 0), 3, 16'h0003, 0, 0, 0, 0);
    tbl[5]  = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 2, 16'h0005, 0, 0, 0, 0);
    tbl[6]  = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 1, 16'h000A, 0, 0, 0, 0);
    tbl[7]  = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 0, 16'h000A, 1, 0, 0, 0);
    tbl[8]  = mk(mi(0, 16'h0000, 0, 0, 1, 16'h1111, 0), 1, 16'h1111, 0, 0, 0, 0);
    tbl[9]  = mk(mi(0, 16'h0000, 0, 0, 1, 16'h2222, 0), 2, 16'h1111, 0, 0, 0, 0);
    tbl[10] = mk(mi(0, 16'h0000, 0, 1, 1, 16'h1234, 0), 2, 16'h2222, 0, 0, 0, 0);
    tbl[11] = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 1, 16'h1234, 0, 0, 0, 0);
    tbl[12] = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 0, 16'h1234, 1, 0, 0, 0);
    tbl[13] = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 0, 16'h1234, 1, 1, 0, 0);
    tbl[14] = mk(mi(0, 16'h0000, 0, 0, 0, 16'h0000, 1), 0, 16'h1234, 1, 1, 0, 0);
    tbl[15] = mk(mi(0, 16'h0000, 0, 1, 0, 16'h0000, 0), 0, 16'h1234, 1, 1, 0, 0);
    tbl[16] = mk(mi(0, 16'h0000, 1, 0, 0, 16'h0000, 0), 0, 16'h1234, 1, 0, 0, 1);
    tbl[17] = mk(mi(1, 16'h0042, 0, 0, 0, 16'h0000, 0), 1, 16'h0042, 0, 0, 0, 1);
    tbl[18] = mk(mi(0, 16'h0000, 1, 0, 0, 16'h0000, 0), 1, 16'h0042, 0, 0, 1, 0);
    tbl[19] = mk(mi(0, 16'h0000, 0, 0, 0, 16'h0000, 1), 0, 16'h0042, 1, 0, 0, 0);
    tbl[20] = mk(mi(0, 16'h0000, 1, 0, 0, 16'h0000, 0), 0, 16'h0042, 1, 0, 0, 1);
    tbl[21] = mk(mi(0, 16'h0000, 1, 0, 0, 16'h0000, 0), 0, 16'h0042, 1, 0, 0, 0);
    tbl[22] = mk(mi(0, 16'h0000, 0, 0, 1, 16'h9999, 0), 0, 16'h0042, 1, 0, 0, 0);

    // Reset values
    #12;
    chk("rst_count",  32'(cn[2]), 0);
    chk("rst_empty",  32'(em[2]), 1);
    chk("rst_full",   32'(fu[2]), 0);
    chk("rst_ready",  32'(lr[2]), 0);
    chk("rst_start",  32'(st[2]), 0);
    chk("rst_ovf",    32'(ov[2]), 0);
    chk("rst_unf",    32'(un[2]), 0);
    chk("rst_option", 32'(op[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main stream on the 1024-deep instance
    for (int r = 0; r < 23; r++) begin
      step(tbl[r].i);
      chk($sformatf("t%0d_count", r),  32'(cn[2]), 32'(tbl[r].cnt));
      chk($sformatf("t%0d_option", r), 32'(op[2]), 32'(tbl[r].opt));
      chk($sformatf("t%0d_empty", r),  32'(em[2]), 32'(tbl[r].emp));
      chk($sformatf("t%0d_unf", r),    32'(un[2]), 32'(tbl[r].unf));
      chk($sformatf("t%0d_start", r),  32'(st[2]), 32'(tbl[r].st));
      chk($sformatf("t%0d_ready", r),  32'(lr[2]), 32'(tbl[r].lrdy));
      chk($sformatf("t%0d_full", r),   32'(fu[2]), 0);
    end
    step(nop);

    // DEPTH=4: full handling
    sel = 0;
    for (int k = 1; k <= 4; k++) step(mi(1, 16'(k), 0, 0, 0, 0, 0));
    chk("d4_fill_count", 32'(cn[0]), 4);
    chk("d4_fill_full",  32'(fu[0]), 1);
    chk("d4_fill_ready", 32'(lr[0]), 0);
    step(mi(1, 16'h0055, 0, 0, 0, 0, 0));
    chk("d4_loadfull_count", 32'(cn[0]), 4);
    step(mi(0, 0, 1, 0, 0, 0, 0));
    chk("d4_started", 32'(st[0]), 1);
    step(mi(0, 0, 0, 1, 1, 16'hCAFE, 0));
    chk("d4_pp_count", 32'(cn[0]), 4);
    chk("d4_pp_ovf",   32'(ov[0]), 0);
    chk("d4_pp_opt",   32'(op[0]), 16'h0002);
    step(mi(0, 0, 0, 0, 1, 16'hBEEF, 0));
    chk("d4_ovf_count", 32'(cn[0]), 4);
    chk("d4_ovf_full",  32'(fu[0]), 1);
    chk("d4_ovf_flag",  32'(ov[0]), 1);
    step(mi(0, 0, 0, 1, 0, 0, 0));
    chk("d4_pop1", 32'(op[0]), 16'h0003);
    step(mi(0, 0, 0, 1, 0, 0, 0));
    chk("d4_pop2", 32'(op[0]), 16'h0004);
    step(mi(0, 0, 0, 1, 0, 0, 0));
    chk("d4_pop3", 32'(op[0]), 16'hCAFE);
    chk("d4_pop3_count", 32'(cn[0]), 1);
    step(mi(0, 0, 0, 1, 0, 0, 0));
    chk("d4_drain_empty", 32'(em[0]), 1);
    chk("d4_drain_opt",   32'(op[0]), 16'hCAFE);
    chk("d4_ovf_sticky",  32'(ov[0]), 1);
    step(nop);

    // DEPTH=5: wrap with constant occupancy
    sel = 1;
    q = {};
    for (int k = 0; k < 3; k++) begin
      step(mi(1, 16'h0010 + 16'(k), 0, 0, 0, 0, 0));
      q.push_back(16'h0010 + 16'(k));
    end
    step(mi(0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 12; k++) begin
      step(mi(0, 0, 0, 1, 1, 16'h0020 + 16'(k), 0));
      void'(q.pop_front());
      q.push_back(16'h0020 + 16'(k));
      chk($sformatf("d5_wrap%0d_opt", k),   32'(op[1]), 32'(q[0]));
      chk($sformatf("d5_wrap%0d_count", k), 32'(cn[1]), 3);
    end
    for (int k = 0; k < 3; k++) begin
      void'(q.pop_front());
      step(mi(0, 0, 0, 1, 0, 0, 0));
      if (q.size() != 0) chk($sformatf("d5_drain%0d_opt", k), 32'(op[1]), 32'(q[0]));
    end
    chk("d5_drain_empty", 32'(em[1]), 1);
    chk("d5_drain_unf",   32'(un[1]), 0);
    step(mi(0, 0, 0, 1, 1, 16'h0077, 0));
    chk("d5_emptypp_count", 32'(cn[1]), 1);
    chk("d5_emptypp_unf",   32'(un[1]), 1);
    chk("d5_emptypp_opt",   32'(op[1]), 16'h0077);
    step(nop);

    // Async reset mid-RUN with 7 words stored, during the started pulse
    sel = 2;
    for (int k = 1; k <= 7; k++) step(mi(1, 16'h0100 + 16'(k), 0, 0, 0, 0, 0));
    step(mi(0, 0, 1, 0, 0, 0, 0));
    drv = nop;
    chk("rr_pre_count", 32'(cn[2]), 7);
    chk("rr_pre_start", 32'(st[2]), 1);
`ifdef OPTION_FIFO_HWM_EN
    chk("rr_pre_hwm", 32'(hw[2]), 7);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_count", 32'(cn[2]), 0);
    chk("rr_empty", 32'(em[2]), 1);
    chk("rr_start", 32'(st[2]), 0);
    chk("rr_ready", 32'(lr[2]), 0);
`ifdef OPTION_FIFO_HWM_EN
    chk("rr_hwm", 32'(hw[2]), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(mi(1, 16'h0099, 0, 0, 0, 0, 0));
    chk("rr_idle_ready", 32'(lr[2]), 1);
    chk("rr_idle_count", 32'(cn[2]), 1);
    chk("rr_idle_opt",   32'(op[2]), 16'h0099);
    step(nop);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
